load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 138 +++++++++++++
 tb/tb_load_store_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit between a core request port and a single-word data memory.
// Performs sub-word loads with extension and sub-word stores via read-modify-write.
module load_store_unit #(
   parameter int MEM_WORDS = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_error,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP} state_t;

   state_t      state, state_n;
   logic [31:0] addr_q, wdata_q, rdata_q, rmw_q;
   logic [1:0]  size_q;
   logic        uns_q, write_q, err_q;

   logic        acc_err;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] ld_ext, merged, word_addr;

   assign acc_err = (req_size == 2'b11) ||
                    (req_size == 2'b01 && req_addr[0]) ||
                    (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
                    ({2'b00, req_addr[31:2]} >= MEM_WORDS);

   assign word_addr = {addr_q[31:2], 2'b00};
   assign byte_sel  = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
   assign half_sel  = mem_rdata[{addr_q[1], 4'b0000} +: 16];

   always_comb begin
      case (size_q)
         2'b00:   ld_ext = uns_q ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         2'b01:   ld_ext = uns_q ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
         default: ld_ext = mem_rdata;
      endcase
   end

   // Only the addressed lane of the captured word is replaced.
   always_comb begin
      merged = rmw_q;
      if (size_q == 2'b00) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      else                 merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n   = state;
      req_ready = 1'b0;
      mem_addr  = 32'b0;
      mem_we    = 1'b0;
      mem_wdata = 32'b0;
      rsp_valid = 1'b0;
      rsp_rdata = 32'b0;
      rsp_error = 1'b0;
      case (state)
         IDLE: begin
            req_ready = rst_n;
            if (req_valid) begin
               if (acc_err)                  state_n = RESP;
               else if (!req_write)          state_n = LOAD;
               else if (req_size == 2'b10)   state_n = STORE;
               else                          state_n = RMW_RD;
            end
         end
         LOAD: begin
            mem_addr = word_addr;
            state_n  = RESP;
         end
         STORE: begin
            mem_addr  = word_addr;
            mem_we    = 1'b1;
            mem_wdata = wdata_q;
            state_n   = RESP;
         end
         RMW_RD: begin
            mem_addr = word_addr;
            state_n  = RMW_WR;
         end
         RMW_WR: begin
            mem_addr  = word_addr;
            mem_we    = 1'b1;
            mem_wdata = merged;
            state_n   = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            rsp_error = err_q;
            rsp_rdata = (err_q || write_q) ? 32'b0 : rdata_q;
            state_n   = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         rmw_q   <= '0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         write_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         if (state == IDLE && req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            write_q <= req_write;
            err_q   <= acc_err;
         end
         if (state == LOAD)   rdata_q <= ld_ext;
         if (state == RMW_RD) rmw_q   <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 64-word behavioural memory.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_write, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_error, mem_we;
   logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [0:63];
   int          we_cnt, rsp_cnt;
   logic [31:0] we_addr, we_wdata;

   always #5 clk = ~clk;

   load_store_unit #(.MEM_WORDS(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_error(rsp_error), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_rdata(mem_rdata)
   );

   assign mem_rdata = mem[mem_addr[7:2]];

   always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

   always @(negedge clk) begin
      if (mem_we) begin
         we_cnt   = we_cnt + 1;
         we_addr  = mem_addr;
         we_wdata = mem_wdata;
      end
      if (rsp_valid) rsp_cnt = rsp_cnt + 1;
   end

   // Issues one request from IDLE and reports edges-to-response and response fields.
   task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] rd, output logic er,
                         output logic [31:0] a1);
      we_cnt = 0;
      req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
      req_addr = a; req_wdata = d;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      a1 = mem_addr;
      while (!rsp_valid && lat < 12) begin
         @(posedge clk); #1;
         lat++;
      end
      rd = rsp_rdata;
      er = rsp_error;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", req_ready); end
      checks++;
      if ({rsp_valid, rsp_error, mem_we} !== 3'b000 || rsp_rdata !== 0 || mem_addr !== 0 || mem_wdata !== 0) begin
         errors++;
         $display("FAIL rst_outputs got v=%b e=%b we=%b rd=%h ma=%h wd=%h exp all 0",
                  rsp_valid, rsp_error, mem_we, rsp_rdata, mem_addr, mem_wdata);
      end
      rst_n = 1'b1;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", req_ready); end
   endtask

   task automatic test_loads();
      int lat; logic [31:0] rd, a1; logic er;
      do_req(1'b0, 2'b00, 1'b0, 32'h7, 32'h0, lat, rd, er, a1);
      checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL ldb_signed got %h exp ffffff80", rd); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL ldb_lat got %0d exp 2", lat); end
      checks++; if (a1 !== 32'h4) begin errors++; $display("FAIL ldb_memaddr got %h exp 4", a1); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL ldb_err got %b exp 0", er); end
      do_req(1'b0, 2'b00, 1'b1, 32'h7, 32'h0, lat, rd, er, a1);
      checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL ldb_unsigned got %h exp 00000080", rd); end
      do_req(1'b0, 2'b00, 1'b0, 32'h5, 32'h0, lat, rd, er, a1);
      checks++; if (rd !== 32'h00000012) begin errors++; $display("FAIL ldb_lane1 got %h exp 00000012", rd); end
      do_req(1'b0, 2'b01, 1'b0, 32'h6, 32'h0, lat, rd, er, a1);
      checks++; if (rd !== 32'hFFFF80FF) begin errors++; $display("FAIL ldh_signed got %h exp ffff80ff", rd); end
      do_req(1'b0, 2'b01, 1'b1, 32'h4, 32'h0, lat, rd, er, a1);
      checks++; if (rd !== 32'h00001234) begin errors++; $display("FAIL ldh_unsigned got %h exp 00001234", rd); end
      do_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, lat, rd, er, a1);
      checks++; if (rd !== 32'h80FF1234) begin errors++; $display("FAIL ldw got %h exp 80ff1234", rd); end
   endtask

   task automatic test_subword_store();
      int lat; logic [31:0] rd, a1; logic er;
      do_req(1'b1, 2'b01, 1'b0, 32'h6, 32'h1234BEEF, lat, rd, er, a1);
      checks++; if (we_cnt !== 1) begin errors++; $display("FAIL sth_we_cnt got %0d exp 1", we_cnt); end
      checks++; if (we_wdata !== 32'hBEEF1234) begin errors++; $display("FAIL sth_wdata got %h exp beef1234", we_wdata); end
      checks++; if (we_addr !== 32'h4) begin errors++; $display("FAIL sth_addr got %h exp 4", we_addr); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL sth_lat got %0d exp 3", lat); end
      checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL sth_rsp got e=%b rd=%h exp 0/0", er, rd); end
      do_req(1'b1, 2'b00, 1'b0, 32'h5, 32'hFFFFFFAB, lat, rd, er, a1);
      checks++; if (we_wdata !== 32'hBEEFAB34) begin errors++; $display("FAIL stb_wdata got %h exp beefab34", we_wdata); end
      do_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, lat, rd, er, a1);
      checks++; if (rd !== 32'hBEEFAB34) begin errors++; $display("FAIL stb_readback got %h exp beefab34", rd); end
   endtask

   task automatic test_word_store();
      int lat; logic [31:0] rd, a1; logic er;
      do_req(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF, lat, rd, er, a1);
      checks++; if (we_cnt !== 1) begin errors++; $display("FAIL stw_we_cnt got %0d exp 1", we_cnt); end
      checks++; if (we_addr !== 32'h8) begin errors++; $display("FAIL stw_addr got %h exp 8", we_addr); end
      checks++; if (we_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL stw_wdata got %h exp deadbeef", we_wdata); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL stw_lat got %0d exp 2", lat); end
   endtask

   task automatic test_errors();
      int lat; logic [31:0] rd, a1; logic er;
      do_req(1'b0, 2'b10, 1'b0, 32'h2, 32'h0, lat, rd, er, a1);
      checks++; if (lat !== 1 || er !== 1'b1 || rd !== 0) begin errors++; $display("FAIL err_misalign got lat=%0d e=%b rd=%h exp 1/1/0", lat, er, rd); end
      do_req(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, lat, rd, er, a1);
      checks++; if (lat !== 1 || er !== 1'b1 || rd !== 0) begin errors++; $display("FAIL err_range got lat=%0d e=%b rd=%h exp 1/1/0", lat, er, rd); end
      do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'h12345678, lat, rd, er, a1);
      checks++; if (er !== 1'b1 || we_cnt !== 0) begin errors++; $display("FAIL err_store got e=%b we=%0d exp 1/0", er, we_cnt); end
      do_req(1'b1, 2'b01, 1'b0, 32'h5, 32'h0, lat, rd, er, a1);
      checks++; if (er !== 1'b1 || we_cnt !== 0) begin errors++; $display("FAIL err_half_odd got e=%b we=%0d exp 1/0", er, we_cnt); end
      do_req(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, lat, rd, er, a1);
      checks++; if (er !== 1'b1 || lat !== 1) begin errors++; $display("FAIL err_size got e=%b lat=%0d exp 1/1", er, lat); end
      do_req(1'b0, 2'b10, 1'b0, 32'hFC, 32'h0, lat, rd, er, a1);
      checks++; if (er !== 1'b0 || lat !== 2) begin errors++; $display("FAIL last_word got e=%b lat=%0d exp 0/2", er, lat); end
   endtask

   // Store byte 0x55 at 0x9 with req_valid held; fields change after acceptance and must be ignored.
   task automatic test_back_to_back();
      int lat; logic busy_bad;
      we_cnt = 0; busy_bad = 1'b0;
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h9; req_wdata = 32'h00000055;
      @(posedge clk); #1;
      req_write = 1'b0; req_size = 2'b10; req_addr = 32'h8; req_wdata = 32'hFFFFFFFF;
      lat = 1;
      if (req_ready !== 1'b0) busy_bad = 1'b1;
      while (!rsp_valid && lat < 12) begin
         @(posedge clk); #1;
         lat++;
         if (req_ready !== 1'b0) busy_bad = 1'b1;
      end
      checks++; if (busy_bad !== 1'b0) begin errors++; $display("FAIL busy_ready got high exp low while busy"); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL busy_lat got %0d exp 3", lat); end
      checks++; if (we_cnt !== 1 || we_wdata !== 32'hDEAD55EF) begin errors++; $display("FAIL busy_store got cnt=%0d wd=%h exp 1/dead55ef", we_cnt, we_wdata); end
      @(posedge clk); #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", req_ready); end
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 12) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++; if (lat !== 2 || rsp_rdata !== 32'hDEAD55EF) begin errors++; $display("FAIL b2b_load got lat=%0d rd=%h exp 2/dead55ef", lat, rsp_rdata); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      logic bad;
      bad = 1'b0;
      we_cnt = 0;
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h000000AA;
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      rsp_cnt = 0;
      repeat (3) begin
         if (mem_we !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 0 || rsp_error !== 1'b0 ||
             mem_addr !== 0 || mem_wdata !== 0 || req_ready !== 1'b0) bad = 1'b1;
         @(posedge clk); #1;
      end
      checks++; if (bad !== 1'b0) begin errors++; $display("FAIL midrst_outputs got nonzero exp all 0"); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b exp 1", req_ready); end
      repeat (5) @(posedge clk);
      #1;
      checks++; if (we_cnt !== 0 || rsp_cnt !== 0) begin errors++; $display("FAIL midrst_activity got we=%0d rsp=%0d exp 0/0", we_cnt, rsp_cnt); end
      checks++; if (mem[0] !== 32'h11111111) begin errors++; $display("FAIL midrst_mem got %h exp 11111111", mem[0]); end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[0] = 32'h11111111;
      mem[1] = 32'h80FF1234;
      mem[63] = 32'hCAFEF00D;
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      we_cnt = 0; rsp_cnt = 0; we_addr = 32'h0; we_wdata = 32'h0;
      test_reset();
      @(posedge clk); #1;
      test_loads();
      test_subword_store();
      test_word_store();
      test_errors();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
